// File: rtl/module_types.sv
// rtl/module_types.sv - shared CDB record type, FU port indices and widths
package module_types;

  localparam int CDB_N_FU     = 4;
  localparam int CDB_ROB_ID_W = 6;
  localparam int CDB_AREG_W   = 5;
  localparam int CDB_PREG_W   = 7;
  localparam int CDB_DATA_W   = 32;

  typedef struct packed {
    logic                    valid;
    logic [CDB_ROB_ID_W-1:0] ROB_id;
    logic [CDB_AREG_W-1:0]   commit_arch_rd_addr;
    logic [CDB_PREG_W-1:0]   commit_phys_rd_addr;
    logic [CDB_DATA_W-1:0]   data;
  } cdb_output_t;

  typedef enum logic [$clog2(CDB_N_FU)-1:0] {
    FU_ALU = 0,
    FU_MUL = 1,
    FU_DIV = 2,
    FU_BR  = 3
  } fu_port_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit side of the CDB: result records and stalls
interface cdb_arbiter_if #(
  parameter int N_FU = module_types::CDB_N_FU
);

  module_types::cdb_output_t [N_FU-1:0] fu_cdb_info;
  logic [N_FU-1:0]                      fu_stall;

  modport master (output fu_cdb_info, input fu_stall);
  modport slave  (input fu_cdb_info, output fu_stall);

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate requests by ptr, find first, map back to a port
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [N-1:0] rot;
  logic [W-1:0] first;

  // ptr_i < N and offsets < N, so one conditional subtract is a full modulo
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    rot     = '0;
    first   = '0;
    any_o   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req_i[W'(wrap(int'(ptr_i) + j))];
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        first = W'(j);
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      idx_o          = W'(wrap(int'(ptr_i) + int'(first)));
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB arbiter, one broadcast per cycle; CDB_ARB_RR_EN selects round-robin
module cdb_arbiter import module_types::*; #(
  parameter int N_FU  = CDB_N_FU,
  parameter int SRC_W = $clog2(N_FU)
) (
  input  logic             clk,
  input  logic             rst,
  cdb_arbiter_if.slave     fu,
  output cdb_output_t      cdb_out,
  output logic [SRC_W-1:0] cdb_src
);

  logic [N_FU-1:0]  req;
  logic [N_FU-1:0]  grant;
  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] pick_ptr;
  logic             any_grant;
  cdb_output_t      win_rec;
  cdb_output_t      cdb_out_q, cdb_out_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

  for (genvar gi = 0; gi < N_FU; gi++) begin : g_req
    assign req[gi] = fu.fu_cdb_info[gi].valid;
  end

  rr_priority_pick #(.N(N_FU), .W(SRC_W)) u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_grant)
  );

  assign fu.fu_stall = req & ~grant;

`ifdef CDB_ARB_RR_EN
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (win_idx == SRC_W'(N_FU - 1)) ? '0 : win_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign pick_ptr = rr_ptr_q;
`else
  assign pick_ptr = '0;
`endif

  // x0 writes still complete in the ROB, only the data is suppressed
  always_comb begin
    win_rec = fu.fu_cdb_info[win_idx];
    if (win_rec.commit_arch_rd_addr == '0) win_rec.data = '0;
    cdb_out_d = '0;
    cdb_src_d = '0;
    if (any_grant) begin
      cdb_out_d = win_rec;
      cdb_src_d = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_out_q <= '0;
      cdb_src_q <= '0;
    end else begin
      cdb_out_q <= cdb_out_d;
      cdb_src_q <= cdb_src_d;
    end
  end

  assign cdb_out = cdb_out_q;
  assign cdb_src = cdb_src_q;

  // a stalled unit owns the only copy of its result, so it must not change it
  for (genvar gi = 0; gi < N_FU; gi++) begin : g_hold_chk
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      fu.fu_stall[gi] |=> (fu.fu_cdb_info[gi] == $past(fu.fu_cdb_info[gi])));
  end

endmodule
